// File: rtl/game_pkg.sv
// Shared game types.
// Player heading enum used by the motion and direction logic.
package game_pkg;
    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        RIGHT = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        UP    = 3'd4
    } directions;
endpackage

// File: rtl/player_motion_if.sv
// Control and position bundle for player_motion.
// master drives enable/headings, slave returns heads and status.
interface player_motion_if #(
    parameter int GRID_W = 32,
    parameter int GRID_H = 24
);
    import game_pkg::*;
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    logic          game_en;
    directions     direction_1;
    directions     direction_2;
    logic          step;
    logic [XW-1:0] pos_x1;
    logic [YW-1:0] pos_y1;
    logic [XW-1:0] pos_x2;
    logic [YW-1:0] pos_y2;
    logic          crash_1;
    logic          crash_2;
    logic          round_over;

    modport master (
        output game_en, direction_1, direction_2,
        input  step, pos_x1, pos_y1, pos_x2, pos_y2,
        input  crash_1, crash_2, round_over
    );

    modport slave (
        input  game_en, direction_1, direction_2,
        output step, pos_x1, pos_y1, pos_x2, pos_y2,
        output crash_1, crash_2, round_over
    );
endinterface

// File: rtl/player_motion.sv
// Two-player head motion on a tick, with wall and
// head-to-head crash detection that freezes the round.
module player_motion
    import game_pkg::*;
#(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int TICK_DIV = 2000000,
    parameter int START_X1 = 4,
    parameter int START_Y1 = 12,
    parameter int START_X2 = 27,
    parameter int START_Y2 = 12
) (
    input logic            clk,
    input logic            rst_n,
    player_motion_if.slave bus
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [XW:0]   XMAX = GRID_W[XW:0] - 1'b1;
    localparam logic [YW:0]   YMAX = GRID_H[YW:0] - 1'b1;
    localparam logic [CW-1:0] CMAX = TICK_DIV[CW-1:0] - 1'b1;
    localparam logic [XW-1:0] SX1  = START_X1[XW-1:0];
    localparam logic [YW-1:0] SY1  = START_Y1[YW-1:0];
    localparam logic [XW-1:0] SX2  = START_X2[XW-1:0];
    localparam logic [YW-1:0] SY2  = START_Y2[YW-1:0];

    typedef enum logic [1:0] {IDLE, RUN, CRASHED} state_t;

    typedef struct packed {
        logic [XW:0] x;
        logic [YW:0] y;
        logic        wall;
    } cand_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [XW-1:0] x1, x1_n, x2, x2_n;
    logic [YW-1:0] y1, y1_n, y2, y2_n;
    logic          c1, c1_n, c2, c2_n;
    logic          step, step_n;
    logic          over, over_n;

    cand_t         m1, m2;
    logic [XW-1:0] h1x, h2x;
    logic [YW-1:0] h1y, h2y;
    logic          coll;

    // One bit wider than the position so that a wrap past
    // either edge shows up as an out-of-range value.
    function automatic cand_t move(
        input directions     d,
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        cand_t c;
        c.x    = {1'b0, x};
        c.y    = {1'b0, y};
        c.wall = 1'b0;
        case (d)
            RIGHT:   c.x = {1'b0, x} + 1'b1;
            LEFT:    c.x = {1'b0, x} - 1'b1;
            DOWN:    c.y = {1'b0, y} + 1'b1;
            UP:      c.y = {1'b0, y} - 1'b1;
            default: ;
        endcase
        c.wall = (c.x > XMAX) || (c.y > YMAX);
        return c;
    endfunction

    // Candidate heads; a wall hit holds that player in place.
    always_comb begin
        m1   = move(bus.direction_1, x1, y1);
        m2   = move(bus.direction_2, x2, y2);
        h1x  = m1.wall ? x1 : m1.x[XW-1:0];
        h1y  = m1.wall ? y1 : m1.y[YW-1:0];
        h2x  = m2.wall ? x2 : m2.x[XW-1:0];
        h2y  = m2.wall ? y2 : m2.y[YW-1:0];
        coll = ((h1x == h2x) && (h1y == h2y)) ||
               ((h1x == x2) && (h1y == y2) &&
                (h2x == x1) && (h2y == y1));
    end

    // Next-state and next-output logic; game_en low wins.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        x1_n    = x1;
        y1_n    = y1;
        x2_n    = x2;
        y2_n    = y2;
        c1_n    = c1;
        c2_n    = c2;
        step_n  = 1'b0;
        if (!bus.game_en) begin
            state_n = IDLE;
            cnt_n   = '0;
            x1_n    = SX1;
            y1_n    = SY1;
            x2_n    = SX2;
            y2_n    = SY2;
            c1_n    = 1'b0;
            c2_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = RUN;
                    cnt_n   = '0;
                    x1_n    = SX1;
                    y1_n    = SY1;
                    x2_n    = SX2;
                    y2_n    = SY2;
                end
                RUN: begin
                    cnt_n = (cnt == CMAX) ? '0 : cnt + 1'b1;
                    if (cnt == CMAX) begin
                        step_n = 1'b1;
                        if (coll) begin
                            c1_n = 1'b1;
                            c2_n = 1'b1;
                        end else begin
                            c1_n = m1.wall;
                            c2_n = m2.wall;
                            x1_n = h1x;
                            y1_n = h1y;
                            x2_n = h2x;
                            y2_n = h2y;
                        end
                        if (coll || m1.wall || m2.wall)
                            state_n = CRASHED;
                    end
                end
                CRASHED: ;
                default: state_n = IDLE;
            endcase
        end
        over_n = (state_n == CRASHED);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Counter, positions and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            x1   <= SX1;
            y1   <= SY1;
            x2   <= SX2;
            y2   <= SY2;
            c1   <= 1'b0;
            c2   <= 1'b0;
            step <= 1'b0;
            over <= 1'b0;
        end else begin
            cnt  <= cnt_n;
            x1   <= x1_n;
            y1   <= y1_n;
            x2   <= x2_n;
            y2   <= y2_n;
            c1   <= c1_n;
            c2   <= c2_n;
            step <= step_n;
            over <= over_n;
        end
    end

    assign bus.step       = step;
    assign bus.pos_x1     = x1;
    assign bus.pos_y1     = y1;
    assign bus.pos_x2     = x2;
    assign bus.pos_y2     = y2;
    assign bus.crash_1    = c1;
    assign bus.crash_2    = c2;
    assign bus.round_over = over;
endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Consumes the per-player direction state (`directions` enum from `game_pkg`: WAIT, RIGHT, DOWN, LEFT, UP) produced by the mouse-driven direction logic.
- Advances each player's head cell on a fixed-rate game tick.
- Detects wall exits and head-to-head collisions, then freezes the round.
- Outputs feed the trail memory and the VGA draw blocks.

Parameters:
- GRID_W, 32, grid width in cells; x range 0..GRID_W-1
- GRID_H, 24, grid height in cells; y range 0..GRID_H-1
- TICK_DIV, 2000000, clk cycles per move step; must be >= 2
- START_X1, 4, player 1 start x
- START_Y1, 12, player 1 start y
- START_X2, 27, player 2 start x
- START_Y2, 12, player 2 start y

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- game_en  in  1  round enable; low returns the block to idle/start positions
- direction_1  in  directions  player 1 heading
- direction_2  in  directions  player 2 heading
- step  out  1  one-cycle pulse; the position outputs changed on this edge
- pos_x1  out  $clog2(GRID_W)  player 1 head x
- pos_y1  out  $clog2(GRID_H)  player 1 head y
- pos_x2  out  $clog2(GRID_W)  player 2 head x
- pos_y2  out  $clog2(GRID_H)  player 2 head y
- crash_1  out  1  sticky; player 1 lost
- crash_2  out  1  sticky; player 2 lost
- round_over  out  1  high in CRASHED state

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE, tick counter=0, positions=START_*, step=0, crash_1=crash_2=0, round_over=0. All outputs are registered.
- FSM states: IDLE, RUN, CRASHED.
  - IDLE: counter held at 0, positions held at START_*. game_en=1 -> RUN next cycle.
  - RUN: counter increments every cycle and wraps at TICK_DIV-1. The wrap cycle is the "tick".
  - CRASHED: counter, positions and crash flags frozen; round_over=1.
  - Any state: game_en=0 -> IDLE next cycle, reloading START_* and clearing crash flags and counter. game_en has priority over a simultaneous tick.
- Tick evaluation, per player, from the direction value sampled in the tick cycle:
  - WAIT: no move.
  - RIGHT: x+1. LEFT: x-1. DOWN: y+1. UP: y-1.
  - Undefined enum value: treated as WAIT.
- Wall rule: no wrap-around. A move from x=GRID_W-1 RIGHT, x=0 LEFT, y=GRID_H-1 DOWN or y=0 UP is a wall hit.
  - That player's position is held and its crash flag is set.
  - The other player still moves unless it also crashes.
- Head collision: a collision sets both crash flags.
  - Both candidate positions equal, or
  - the players swap cells (cand1==pos2 and cand2==pos1).
  - On collision, neither position updates.
- Any crash flag set at a tick -> CRASHED next cycle. Positions and flags become visible on the same edge.
- step=1 for exactly one cycle, on the edge where a tick is processed in RUN, including ticks where both players are WAIT or a crash occurs. step=0 in IDLE and CRASHED.
- Latency: direction change to position change <= TICK_DIV cycles; position registers update on the tick edge, 0 extra pipeline delay.
- Arithmetic: candidate coordinates are computed one bit wider than the position to detect underflow and overflow; only in-range values are stored.
- Trail/body collision is out of scope; it belongs to the trail memory.

Test Plan:
1. Reset with TICK_DIV=4, then game_en=1, both directions WAIT for 12 cycles -> step pulses every 4 cycles; positions stay (4,12)/(27,12); crash flags stay 0.
2. direction_1=RIGHT, direction_2=LEFT for 3 ticks -> after 3 step pulses pos_x1=7, pos_x2=24; y values unchanged at 12.
3. Start (START_X1=0) with direction_1=LEFT -> first tick: crash_1=1, crash_2=0, pos_x1=0, round_over=1 next cycle; further ticks produce no step and no movement.
4. Heads at (15,12)/(17,12), RIGHT/LEFT -> both candidates are (16,12); crash_1=crash_2=1 and positions stay (15,12)/(17,12). Repeat from adjacent cells (15,12)/(16,12) -> swap detected, both crash.
5. Deassert game_en in CRASHED, and separately in RUN on a tick cycle -> IDLE next cycle; positions back to START_*, flags cleared, no step pulse.
6. Assert rst_n=0 mid-RUN, between clock edges -> outputs reset immediately without waiting for clk; motion resumes from START_* after release with game_en=1.
